// File: rtl/dmem_sized.sv
// dmem_sized - sized, handshaked, byte-addressed data memory.
//
// Accepts one request at a time on a valid/ready handshake. The request is
// captured into registers, held for LATENCY cycles, then performed against
// the byte array. The result is presented on a valid/ready response channel.
// Accesses are 1/2/4/8 bytes, little-endian. Loads are sign- or zero-extended.
// Any access with addr + N > DEPTH faults: no write, rsp_err = 1, rdata = 0.
//
// Optional build macro:
//   DMEM_MISALIGN_TRAP_EN - when defined, accesses with addr mod N != 0 also
//                           fault. When undefined, misaligned accesses are
//                           performed byte-wise.
//
// Parameters:
//   DEPTH   - memory size in bytes (>= 8)
//   LATENCY - cycles from request acceptance to response (1..15)
//
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   req_valid/ready   - request handshake
//   req_we            - 1 = store, 0 = load
//   req_size          - 0 byte, 1 half, 2 word, 3 double
//   req_unsigned      - loads: 1 = zero-extend, 0 = sign-extend
//   req_addr          - byte address
//   req_wdata         - store data, right-justified
//   rsp_valid/ready   - response handshake
//   rsp_rdata         - load result (0 for stores and faults)
//   rsp_err           - access faulted
module dmem_sized #(
    parameter int DEPTH   = 8192,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [7:0]  mem_q [DEPTH];

    // Captured request
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [3:0]  cnt_q;

    // Registered outputs
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [63:0] rsp_rdata_q;

    // Access evaluation on the captured request
    logic [3:0]    nbytes;
    logic [64:0]   end_addr;
    logic          fault_d;
    logic [AW-1:0] idx [8];
    logic [63:0]   raw;
    logic [63:0]   rdata_d;

    assign nbytes   = 4'd1 << size_q;
    // 65-bit sum so an address near 2^64 cannot wrap into range
    assign end_addr = {1'b0, addr_q} + 65'(nbytes);

    always_comb begin
        fault_d = (end_addr > 65'(DEPTH));
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((addr_q[2:0] & 3'(nbytes - 4'd1)) != 3'd0)
            fault_d = 1'b1;
`endif
    end

    always_comb begin
        raw = '0;
        for (int k = 0; k < 8; k++) begin
            idx[k] = AW'(addr_q + 64'(k));
            if ((k < int'(nbytes)) && !fault_d)
                raw[8*k +: 8] = mem_q[idx[k]];
        end
    end

    // Sign bit is the top bit of the accessed width; doubles need none
    always_comb begin
        rdata_d = raw;
        case (size_q)
            2'd0:    rdata_d = {{56{~uns_q & raw[7]}},  raw[7:0]};
            2'd1:    rdata_d = {{48{~uns_q & raw[15]}}, raw[15:0]};
            2'd2:    rdata_d = {{32{~uns_q & raw[31]}}, raw[31:0]};
            default: rdata_d = raw;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q        <= req_we;
                        size_q      <= req_size;
                        uns_q       <= req_unsigned;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        cnt_q       <= 4'(LATENCY - 1);
                        req_ready_q <= 1'b0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    // Access commits LATENCY edges after acceptance
                    if (cnt_q == 4'd0) begin
                        if (we_q && !fault_d) begin
                            for (int k = 0; k < 8; k++)
                                if (k < int'(nbytes))
                                    mem_q[idx[k]] <= wdata_q[8*k +: 8];
                        end
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= fault_d;
                        rsp_rdata_q <= (we_q || fault_d) ? 64'd0 : rdata_d;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
